alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Multi-cycle ALU that sits directly upstream of the accumulator: it takes the
//  AC value (operand A) and a bus operand (B), computes, and returns the result
//  on result with a one-cycle done pulse that drives the AC write strobe.
//  Single-cycle ops complete in 1 cycle; MUL/DIV iterate one bit per cycle.
// PARAMETERS
//  WIDTH  24  datapath width (operands, result)
//  CNT_W   5  iteration counter width; must satisfy 2**CNT_W >= WIDTH
// PORTS
//  clk       in   1      rising-edge clock; single clock domain
//  reset     in   1      asynchronous, active-low reset
//  start     in   1      request; sampled only in IDLE
//  op        in   4      opcode (see alu_pkg)
//  a_in      in   WIDTH  operand A (accumulator value)
//  b_in      in   WIDTH  operand B (bus value)
//  result    out  WIDTH  registered result; held until next completion
//  done      out  1      one-cycle pulse when result is valid (AC write)
//  busy      out  1      high from the cycle after start is accepted until done
//  z_flag    out  1      result == 0, updated with result
//  c_flag    out  1      carry/borrow/shifted-out bit, updated with result
//  dz_flag   out  1      divide by zero on last DIV, else 0
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, result=0, done=0, busy=0, all flags 0,
//    counter=0. Reset mid-MUL/DIV aborts; no done is produced.
//  - FSM: IDLE -> (start) EXEC for single-cycle ops, or CALC for MUL/DIV.
//    EXEC -> DONE. CALC -> DONE when counter reaches WIDTH-1. DONE -> IDLE.
//  - Operands and op are captured on the accepting edge; later a_in/b_in/op
//    changes do not affect the running operation.
//  - done=1 only in DONE. Latency from the accepting edge: 2 edges (single-cycle
//    ops), WIDTH+2 edges (MUL/DIV). busy=1 in EXEC/CALC/DONE.
//  - start while not IDLE is ignored (not queued). start in DONE's cycle is
//    ignored; a new op is accepted at the earliest in the following IDLE cycle.
//  - Ops: PASS_B=B; ADD=A+B, c=carry out; SUB=A-B, c=borrow (A<B unsigned);
//    INC=A+1, c=carry; AND/OR/XOR bitwise; NOT=~A; SHL=A<<1, c=A[MSB];
//    SHR=A>>1 logical, c=A[0]; MUL=low WIDTH bits of unsigned A*B (shift-add),
//    c=1 if any high-half bit nonzero; DIV=unsigned A/B (restoring), c=0.
//  - c_flag=0 for logical ops and PASS_B. Undefined opcodes behave as PASS_B.
//  - DIV with B=0: result all ones, dz_flag=1, still takes WIDTH+2 edges.
//  - All arithmetic wraps modulo 2**WIDTH; no saturation.
//  - Flags and result are updated only on the edge entering DONE.
// STRUCTURE
//  - alu_pkg: op encodings (PASS_B=0, ADD=1, SUB=2, INC=3, AND=4, OR=5, XOR=6,
//    NOT=7, SHL=8, SHR=9, MUL=10, DIV=11), FSM state encodings, WIDTH default.
//  - Sub-module alu_muldiv_iter: shift-add multiplier / restoring divider with
//    load, step and mode inputs, product/quotient and overflow outputs. The top
//    holds the FSM, counter, single-cycle datapath, result/flag registers.
// TESTING
//  - Reset: reset=0 mid-MUL at iteration 10 -> all outputs 0, no done; after
//    release, ADD 5+7 -> result=12, done one cycle, 2 edges after accept.
//  - ADD 24'hFFFFFF+1 -> result=0, z=1, c=1; SUB 3-5 -> 24'hFFFFFE, c=1, z=0.
//  - MUL 24'h001000*24'h000800 -> result=24'h800000, c=0; 24'h100000*16 ->
//    result=0, c=1, z=1; done exactly WIDTH+2 edges after accept, busy until done.
//  - DIV 100/7 -> 14; DIV 9/0 -> 24'hFFFFFF, dz=1; next ADD clears dz to 0.
//  - start held high throughout MUL with changing op/a_in/b_in -> result uses
//    captured operands; second op accepted only after DONE, back-to-back count.
//  - SHL 24'h800001 -> 24'h000002, c=1; SHR 24'h000001 -> 0, c=1, z=1; op=15 ->
//    result=b_in.

Source files
------------

// File: rtl/alu_pkg.sv
// Package for the sequential ALU that feeds the accumulator.
// Contents:
//   - default datapath width and iteration counter width
//   - opcode encodings
//   - FSM state encodings
//   - a helper that marks the opcodes needing the iterative unit
package alu_pkg;

    localparam int ALU_WIDTH = 24;
    localparam int ALU_CNT_W = 5;

    typedef enum logic [3:0] {
        OP_PASS_B = 4'd0,
        OP_ADD    = 4'd1,
        OP_SUB    = 4'd2,
        OP_INC    = 4'd3,
        OP_AND    = 4'd4,
        OP_OR     = 4'd5,
        OP_XOR    = 4'd6,
        OP_NOT    = 4'd7,
        OP_SHL    = 4'd8,
        OP_SHR    = 4'd9,
        OP_MUL    = 4'd10,
        OP_DIV    = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

    // MUL and DIV go through the one-bit-per-cycle unit; everything else is
    // single cycle.
    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier / divider, one bit per step.
// Ports:
//   clk      clock
//   load     initialise the working registers from a/b (mode selects layout)
//   step     perform one iteration
//   mode     0 = shift-add multiply, 1 = restoring divide
//   a, b     operands (multiplicand/dividend = a, multiplier/divisor = b)
//   res_next low product / quotient as it will be after the current step
//   ovf_next multiply only: high half of the product nonzero after the step
// The outputs reflect the post-step value so the caller can register the
// final answer on the same edge as the last step.
module alu_muldiv_iter #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_next,
    output logic             ovf_next
);

    // hi: partial product high half / partial remainder
    // lo: multiplier being shifted out / dividend shifting out, quotient in
    // opnd: multiplicand / divisor
    logic [WIDTH-1:0] hi, lo, opnd;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic [WIDTH:0]   sum, sh, diff;

    always_comb begin
        hi_n = hi;
        lo_n = lo;
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        sh   = {hi, lo[WIDTH-1]};
        diff = sh - {1'b0, opnd};
        if (!mode) begin
            // Add-then-shift-right: the carry of the add becomes the new MSB.
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            // Trial subtraction fits: keep the difference, quotient bit 1.
            hi_n = diff[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_n = sh[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            hi   <= '0;
            lo   <= mode ? a : b;
            opnd <= mode ? b : a;
        end else if (step) begin
            hi <= hi_n;
            lo <= lo_n;
        end
    end

    assign res_next = lo_n;
    assign ovf_next = !mode && (|hi_n);

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU in front of the accumulator.
// Ports:
//   clk, reset (async, active low)
//   start    request, only taken in IDLE
//   op       opcode (alu_pkg::alu_op_e; undefined codes act as PASS_B)
//   a_in     operand A (accumulator), b_in operand B (bus)
//   result   registered result, held until the next completion
//   done     one-cycle pulse in DONE (accumulator write strobe)
//   busy     high in EXEC/CALC/DONE
//   z_flag, c_flag, dz_flag  zero / carry-borrow-shift-out / divide by zero
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = ALU_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             z_flag,
    output logic             c_flag,
    output logic             dz_flag
);

    alu_state_e       state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             first_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             accept, calc_last, div_zero;
    logic [WIDTH:0]   single;
    logic [WIDTH-1:0] iter_res, calc_res;
    logic             iter_ovf;

    // Single-cycle operations; the extra top bit carries c_flag.
    function automatic logic [WIDTH:0] alu_single(input logic [3:0] f_op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (f_op)
            OP_ADD:  alu_single = {1'b0, a} + {1'b0, b};
            OP_SUB:  alu_single = {1'b0, a} - {1'b0, b};  // MSB is the borrow
            OP_INC:  alu_single = {1'b0, a} + (WIDTH+1)'(1);
            OP_AND:  alu_single = {1'b0, a & b};
            OP_OR:   alu_single = {1'b0, a | b};
            OP_XOR:  alu_single = {1'b0, a ^ b};
            OP_NOT:  alu_single = {1'b0, ~a};
            OP_SHL:  alu_single = {a, 1'b0};
            OP_SHR:  alu_single = {a[0], 1'b0, a[WIDTH-1:1]};
            default: alu_single = {1'b0, b};
        endcase
    endfunction

    assign accept    = (state == ST_IDLE) && start;
    // The first CALC cycle only loads the iterator; steps follow.
    assign calc_last = (state == ST_CALC) && !first_q && (cnt == CNT_W'(WIDTH - 1));
    assign div_zero  = (op_q == OP_DIV) && (b_q == '0);
    assign single    = alu_single(op_q, a_q, b_q);
    assign calc_res  = div_zero ? '1 : iter_res;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        done    = 1'b0;
        busy    = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_n = is_iter_op(op) ? ST_CALC : ST_EXEC;
            end
            ST_EXEC: state_n = ST_DONE;
            ST_CALC: if (calc_last) state_n = ST_DONE;
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            first_q <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            first_q <= 1'b1;
        end else if (state == ST_CALC) begin
            if (first_q) first_q <= 1'b0;
            else         cnt     <= cnt + 1'b1;
        end
    end

    // Operand capture on the accepting edge; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= op;
            a_q  <= a_in;
            b_q  <= b_in;
        end
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .load     ((state == ST_CALC) && first_q),
        .step     ((state == ST_CALC) && !first_q),
        .mode     (op_q == OP_DIV),
        .a        (a_q),
        .b        (b_q),
        .res_next (iter_res),
        .ovf_next (iter_ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result  <= '0;
            z_flag  <= 1'b0;
            c_flag  <= 1'b0;
            dz_flag <= 1'b0;
        end else if (state == ST_EXEC) begin
            result  <= single[WIDTH-1:0];
            z_flag  <= (single[WIDTH-1:0] == '0);
            c_flag  <= single[WIDTH];
            dz_flag <= 1'b0;
        end else if (calc_last) begin
            result  <= calc_res;
            z_flag  <= (calc_res == '0);
            c_flag  <= iter_ovf;
            dz_flag <= div_zero;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [W-1:0] result;
    logic         done, busy, z_flag, c_flag, dz_flag;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a_in    (a_in),
        .b_in    (b_in),
        .result  (result),
        .done    (done),
        .busy    (busy),
        .z_flag  (z_flag),
        .c_flag  (c_flag),
        .dz_flag (dz_flag)
    );

    always #5 clk = ~clk;

    // Issue one operation from IDLE and wait (bounded) for done. edges counts
    // the accepting edge as 1.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic zf, output logic cf,
                          output logic dzf, output int edges, output logic busy_ok,
                          output logic done_after);
        op = o; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        busy_ok = (busy === 1'b1);
        while (done !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        r = result; zf = z_flag; cf = c_flag; dzf = dz_flag;
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset_initial();
        #1;
        n_checks++;
        if ({result, done, busy, z_flag, c_flag, dz_flag} !== '0) begin
            n_fail++;
            $display("FAIL reset_init: got result=%h done=%b busy=%b z=%b c=%b dz=%b, want all 0",
                     result, done, busy, z_flag, c_flag, dz_flag);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_add_sub();
        logic [W-1:0] r; logic zf, cf, dzf, bok, da; int e;
        run_op(OP_ADD, 24'hFFFFFF, 24'h000001, r, zf, cf, dzf, e, bok, da);
        n_checks++;
        if ({r, zf, cf} !== {24'h000000, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL add_wrap: got r=%h z=%b c=%b, want r=000000 z=1 c=1", r, zf, cf);
        end
        n_checks++;
        if (e !== 2) begin
            n_fail++;
            $display("FAIL add_latency: got %0d edges, want 2", e);
        end
        run_op(OP_SUB, 24'd3, 24'd5, r, zf, cf, dzf, e, bok, da);
        n_checks++;
        if ({r, zf, cf} !== {24'hFFFFFE, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_borrow: got r=%h z=%b c=%b, want r=fffffe z=0 c=1", r, zf, cf);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [W-1:0] r; logic zf, cf, dzf, bok, da; int e;
        logic saw_done;
        op = OP_MUL; a_in = 24'h001000; b_in = 24'h000800; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        n_checks++;
        if ({result, done, busy, z_flag, c_flag, dz_flag} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_mul: got result=%h done=%b busy=%b z=%b c=%b dz=%b, want all 0",
                     result, done, busy, z_flag, c_flag, dz_flag);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: got done pulse after aborted MUL, want none");
        end
        @(posedge clk); #1;
        run_op(OP_ADD, 24'd5, 24'd7, r, zf, cf, dzf, e, bok, da);
        n_checks++;
        if ({r, e, da} !== {24'd12, 32'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL add_after_reset: got r=%0d edges=%0d done_after=%b, want r=12 edges=2 done_after=0",
                     r, e, da);
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] r; logic zf, cf, dzf, bok, da; int e;
        run_op(OP_MUL, 24'h001000, 24'h000800, r, zf, cf, dzf, e, bok, da);
        n_checks++;
        if ({r, zf, cf} !== {24'h800000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mul_basic: got r=%h z=%b c=%b, want r=800000 z=0 c=0", r, zf, cf);
        end
        n_checks++;
        if ({e, bok, da} !== {32'd26, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mul_timing: got edges=%0d busy_ok=%b done_after=%b, want 26 1 0", e, bok, da);
        end
        run_op(OP_MUL, 24'h100000, 24'd16, r, zf, cf, dzf, e, bok, da);
        n_checks++;
        if ({r, zf, cf} !== {24'h000000, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL mul_ovf: got r=%h z=%b c=%b, want r=000000 z=1 c=1", r, zf, cf);
        end
        run_op(OP_MUL, 24'd1234, 24'd567, r, zf, cf, dzf, e, bok, da);
        n_checks++;
        if ({r, cf} !== {24'd699678, 1'b0}) begin
            n_fail++;
            $display("FAIL mul_mixed: got r=%0d c=%b, want r=699678 c=0", r, cf);
        end
    endtask

    task automatic test_div();
        logic [W-1:0] r; logic zf, cf, dzf, bok, da; int e;
        run_op(OP_DIV, 24'd100, 24'd7, r, zf, cf, dzf, e, bok, da);
        n_checks++;
        if ({r, cf, dzf, e} !== {24'd14, 1'b0, 1'b0, 32'd26}) begin
            n_fail++;
            $display("FAIL div_basic: got r=%0d c=%b dz=%b edges=%0d, want 14 0 0 26", r, cf, dzf, e);
        end
        run_op(OP_DIV, 24'd9, 24'd0, r, zf, cf, dzf, e, bok, da);
        n_checks++;
        if ({r, cf, dzf, e} !== {24'hFFFFFF, 1'b0, 1'b1, 32'd26}) begin
            n_fail++;
            $display("FAIL div_zero: got r=%h c=%b dz=%b edges=%0d, want ffffff 0 1 26", r, cf, dzf, e);
        end
        run_op(OP_ADD, 24'd1, 24'd1, r, zf, cf, dzf, e, bok, da);
        n_checks++;
        if ({r, dzf} !== {24'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL dz_clear: got r=%0d dz=%b, want r=2 dz=0", r, dzf);
        end
    endtask

    task automatic test_back_to_back();
        int e, gap;
        op = OP_MUL; a_in = 24'd3; b_in = 24'd5; start = 1'b1;
        @(posedge clk); #1;
        e = 1;
        op = OP_SUB; a_in = 24'd77; b_in = 24'd11;
        @(posedge clk); #1;
        e++;
        op = OP_ADD; a_in = 24'd100; b_in = 24'd200;
        while (done !== 1'b1 && e < 100) begin
            @(posedge clk); #1;
            e++;
        end
        n_checks++;
        if ({result, c_flag, e} !== {24'd15, 1'b0, 32'd26}) begin
            n_fail++;
            $display("FAIL held_start_mul: got r=%0d c=%b edges=%0d, want r=15 c=0 edges=26", result, c_flag, e);
        end
        gap = 0;
        do begin
            @(posedge clk); #1;
            gap++;
        end while (done !== 1'b1 && gap < 20);
        start = 1'b0;
        n_checks++;
        if ({result, gap} !== {24'd300, 32'd3}) begin
            n_fail++;
            $display("FAIL back_to_back: got r=%0d gap=%0d edges, want r=300 gap=3", result, gap);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_shift_pass();
        logic [W-1:0] r; logic zf, cf, dzf, bok, da; int e;
        run_op(OP_SHL, 24'h800001, 24'd0, r, zf, cf, dzf, e, bok, da);
        n_checks++;
        if ({r, cf, zf} !== {24'h000002, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL shl: got r=%h c=%b z=%b, want 000002 1 0", r, cf, zf);
        end
        run_op(OP_SHR, 24'h000001, 24'd0, r, zf, cf, dzf, e, bok, da);
        n_checks++;
        if ({r, cf, zf} !== {24'h000000, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL shr: got r=%h c=%b z=%b, want 000000 1 1", r, cf, zf);
        end
        run_op(4'd15, 24'h000123, 24'hABCDEF, r, zf, cf, dzf, e, bok, da);
        n_checks++;
        if ({r, cf, zf} !== {24'hABCDEF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL undef_op: got r=%h c=%b z=%b, want abcdef 0 0", r, cf, zf);
        end
        run_op(OP_XOR, 24'hF0F0F0, 24'hFF00FF, r, zf, cf, dzf, e, bok, da);
        n_checks++;
        if ({r, cf} !== {24'h0FF00F, 1'b0}) begin
            n_fail++;
            $display("FAIL xor: got r=%h c=%b, want 0ff00f 0", r, cf);
        end
    endtask

    initial begin
        test_reset_initial();
        test_add_sub();
        test_reset_mid_mul();
        test_mul();
        test_div();
        test_back_to_back();
        test_shift_pass();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
